// File: rtl/legv8_dmem_responder.sv
// Doubleword data memory behind valid/ready request and response channels.
// One request in flight; each access commits a fixed LATENCY cycles after accept.
module legv8_dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e         state_q;
  logic           idle_q;
  logic [CW-1:0]  cnt_q;
  logic           wr_q;
  logic [63:0]    addr_q;
  logic [63:0]    wdata_q;
  logic           resp_valid_q;
  logic [63:0]    rdata_q;
  logic           err_q;
  logic [63:0]    mem_q [DEPTH_WORDS];

  logic           err_w;
  logic [AW-1:0]  idx_w;
  logic           commit_w;

  assign err_w    = (addr_q[2:0] != 3'b000) || (addr_q[63:3] >= 61'(DEPTH_WORDS));
  assign idx_w    = addr_q[3 +: AW];
  assign commit_w = (state_q == BUSY) && (cnt_q == '0);

  // Gate with resetl so the requester never sees ready while reset is held.
  assign req_ready  = idle_q & resetl;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state_q      <= IDLE;
      idle_q       <= 1'b1;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_write;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            cnt_q   <= CW'(LATENCY - 1);
            idle_q  <= 1'b0;
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CW'(1);
          end else begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            err_q        <= err_w;
            rdata_q      <= (wr_q || err_w) ? 64'd0 : mem_q[idx_w];
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            idle_q       <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          idle_q  <= 1'b1;
        end
      endcase
    end
  end

  // Array is not reset; a reset before the commit edge leaves state_q in IDLE,
  // so an aborted store never reaches the array.
  always_ff @(posedge CLK) begin
    if (commit_w && wr_q && !err_w)
      mem_q[idx_w] <= wdata_q;
  end
endmodule

// File: tb/tb_legv8_dmem_responder.sv
// Randomized check of the data-memory responder at LATENCY 2, 3 and 1,
// against a word-array model addressed by byte address / 8.
module tb_legv8_dmem_responder;
  localparam int ND = 3;
  localparam int DEPTH = 64;
  localparam int LATS [ND] = '{2, 3, 1};

  logic        CLK = 1'b0;
  logic        resetl     [ND];
  logic        req_valid  [ND];
  logic        req_ready  [ND];
  logic        req_write  [ND];
  logic [63:0] req_addr   [ND];
  logic [63:0] req_wdata  [ND];
  logic        resp_valid [ND];
  logic        resp_ready [ND];
  logic [63:0] resp_rdata [ND];
  logic        resp_err   [ND];

  logic [63:0] mdl [ND][DEPTH];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    legv8_dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LATS[g])) u_dut (
      .CLK        (CLK),
      .resetl     (resetl[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_write  (req_write[g]),
      .req_addr   (req_addr[g]),
      .req_wdata  (req_wdata[g]),
      .resp_valid (resp_valid[g]),
      .resp_ready (resp_ready[g]),
      .resp_rdata (resp_rdata[g]),
      .resp_err   (resp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h @cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic bit exp_err(input logic [63:0] a);
    return (a % 8 != 0) || (a / 8 >= DEPTH);
  endfunction

  task automatic do_reset(input int d);
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b0;
    resetl[d]     = 1'b0;
    #1;
    chk("rst_req_ready", req_ready[d], 0);
    chk("rst_resp_valid", resp_valid[d], 0);
    chk("rst_rdata", resp_rdata[d], 0);
    @(negedge CLK);
    @(negedge CLK);
    resetl[d] = 1'b1;
    #1;
    chk("rel_req_ready", req_ready[d], 1);
  endtask

  // Drive a request, wait for it to be accepted, then scramble the request
  // inputs (still valid) to show they are only sampled at the accept edge.
  task automatic send(input int d, input bit wr, input logic [63:0] a,
                      input logic [63:0] wd, output int acc);
    int t;
    @(negedge CLK);
    req_valid[d]  = 1'b1;
    req_write[d]  = wr;
    req_addr[d]   = a;
    req_wdata[d]  = wd;
    resp_ready[d] = 1'b0;
    t = 0;
    while (!req_ready[d] && t < 50) begin
      @(negedge CLK);
      t++;
    end
    chk("accept_ready", req_ready[d], 1);
    @(posedge CLK);
    #1;
    acc = cyc;
    req_write[d] = 1'($urandom);
    req_addr[d]  = {$urandom, $urandom};
    req_wdata[d] = {$urandom, $urandom};
  endtask

  task automatic wait_resp(input int d);
    int n;
    n = 0;
    while (!resp_valid[d] && n < LATS[d] + 8) begin
      chk("busy_req_ready", req_ready[d], 0);
      @(posedge CLK);
      #1;
      n++;
    end
    chk("latency", 64'(n), 64'(LATS[d]));
  endtask

  task automatic recv(input int d, input int stall, output logic [63:0] rd,
                      output logic er, output int hs);
    wait_resp(d);
    rd = resp_rdata[d];
    er = resp_err[d];
    repeat (stall) begin
      @(posedge CLK);
      #1;
      chk("bp_valid", resp_valid[d], 1);
      chk("bp_rdata", resp_rdata[d], rd);
      chk("bp_err", resp_err[d], er);
      chk("bp_req_ready", req_ready[d], 0);
    end
    @(negedge CLK);
    resp_ready[d] = 1'b1;
    @(posedge CLK);
    #1;
    hs = cyc;
    req_valid[d]  = 1'b0;
    resp_ready[d] = 1'b0;
    chk("post_hs_valid", resp_valid[d], 0);
    chk("post_hs_ready", req_ready[d], 1);
  endtask

  task automatic xact(input int d, input bit wr, input logic [63:0] a,
                      input logic [63:0] wd, input int stall,
                      output int acc, output int hs);
    logic [63:0] rd;
    logic        er;
    bit          e;
    int          idx;
    send(d, wr, a, wd, acc);
    recv(d, stall, rd, er, hs);
    e   = exp_err(a);
    idx = int'((a / 8) % DEPTH);
    chk("resp_err", er, e);
    chk("resp_rdata", rd, (wr || e) ? 64'd0 : mdl[d][idx]);
    if (wr && !e) mdl[d][idx] = wd;
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout at cyc %0d", cyc);
    $fatal(1);
  end

  initial begin
    int acc, hs, acc2, hs2, pacc, d, r, stall, gap;
    logic [63:0] a, va, vb;
    bit wr;
    for (int i = 0; i < ND; i++) begin
      resetl[i] = 1'b0; req_valid[i] = 1'b0; req_write[i] = 1'b0;
      req_addr[i] = '0; req_wdata[i] = '0; resp_ready[i] = 1'b0;
    end
    #3;
    for (int i = 0; i < ND; i++) do_reset(i);

    // Known contents everywhere so every load has a defined expectation.
    for (int i = 0; i < ND; i++)
      for (int w = 0; w < DEPTH; w++)
        xact(i, 1'b1, 64'(w * 8), {$urandom, $urandom}, 0, acc, hs);

    // LATENCY=2: store/load, misaligned, out of range, backpressure.
    xact(0, 1'b1, 64'h28, 64'hDEAD_BEEF_0123_4567, 0, acc, hs);
    xact(0, 1'b0, 64'h28, 64'h0, 0, acc, hs);
    xact(0, 1'b1, 64'h2C, 64'h1111_2222_3333_4444, 0, acc, hs);
    xact(0, 1'b0, 64'h28, 64'h0, 0, acc, hs);
    xact(0, 1'b0, 64'h200, 64'h0, 0, acc, hs);
    xact(0, 1'b0, 64'h28, 64'h0, 3, acc, hs);
    xact(0, 1'b0, 64'h30, 64'h0, 0, acc2, hs2);
    chk("bp_reaccept", 64'(acc2), 64'(hs + 1));

    // LATENCY=3: reset one cycle after accept aborts the store.
    va = 64'hAAAA_0000_5555_0001;
    vb = 64'hBBBB_0000_6666_0002;
    xact(1, 1'b1, 64'h10, va, 0, acc, hs);
    send(1, 1'b1, 64'h10, vb, acc);
    @(posedge CLK);
    #1;
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      @(posedge CLK);
      #1;
      chk("abort_no_valid", resp_valid[1], 0);
    end
    xact(1, 1'b0, 64'h10, 64'h0, 0, acc, hs);

    // Reset after the commit edge keeps the store; reset with load data pending clears rdata.
    send(1, 1'b1, 64'h10, vb, acc);
    wait_resp(1);
    do_reset(1);
    mdl[1][2] = vb;
    send(1, 1'b0, 64'h10, 64'h0, acc);
    wait_resp(1);
    chk("pend_load_rdata", resp_rdata[1], vb);
    do_reset(1);
    xact(1, 1'b0, 64'h10, 64'h0, 0, acc, hs);

    // LATENCY=1: back-to-back loads accepted every 3 cycles.
    pacc = 0;
    for (int i = 0; i < 4; i++) begin
      xact(2, 1'b0, 64'(i * 8), 64'h0, 0, acc, hs);
      if (i > 0) chk("b2b_spacing", 64'(acc - pacc), 64'd3);
      pacc = acc;
    end

    for (int n = 0; n < 400; n++) begin
      d  = $urandom_range(0, ND - 1);
      wr = 1'($urandom);
      r  = $urandom_range(0, 9);
      if (r < 7)       a = 64'($urandom_range(0, DEPTH - 1) * 8);
      else if (r == 7) a = 64'($urandom_range(0, DEPTH - 1) * 8 + $urandom_range(1, 7));
      else if (r == 8) a = 64'($urandom_range(DEPTH, 4 * DEPTH) * 8);
      else             a = {$urandom, $urandom} | 64'h8000_0000_0000_0000;
      stall = $urandom_range(0, 3);
      gap   = $urandom_range(0, 2);
      repeat (gap) @(negedge CLK);
      xact(d, wr, a, {$urandom, $urandom}, stall, acc, hs);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/legv8_dmem_responder.md
# legv8_dmem_responder

Data-memory responder for the LEGv8 datapath: it serves 64-bit doubleword loads and stores over a valid/ready request channel and a valid/ready response channel. Each request completes after a fixed, parameterised latency. This replaces the combinational data memory when the datapath is extended to multi-cycle or pipelined operation. It is the memory-side end of the load/store interface that the datapath's LDUR/STUR path drives.

## Interface
- DEPTH_WORDS, 64: number of 64-bit words. Power of two, ≥2.
- LATENCY, 2: cycles from request accept to `resp_valid`. Must be ≥1.
- CLK  input  1  clock. All state updates on the posedge.
- resetl  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store (STUR), 0 = load (LDUR).
- req_addr  input  64  byte address (ALU result).
- req_wdata  input  64  store data (register file BusB).
- resp_valid  output  1  response present.
- resp_ready  input  1  requester takes the response.
- resp_rdata  output  64  load data. 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.

## Operation
- The block allows one outstanding request. The FSM has three states: IDLE, BUSY and RESP.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`&&`req_ready`, latch write, addr and wdata, load the counter with LATENCY-1, and go to BUSY.
- **BUSY**
  - `req_ready`=0.
  - While the counter is nonzero, decrement it.
  - When the counter is 0, go to RESP and perform the access at the same edge (the commit edge).
- **RESP**
  - `resp_valid`=1. `resp_rdata` and `resp_err` hold steady.
  - On `resp_valid`&&`resp_ready`, return to IDLE.
  - There is no same-cycle re-accept: `req_ready` rises in the cycle after the response handshake.
- **Address check**, evaluated on the latched address:
  - Misaligned if `addr[2:0]`≠0.
  - Out of range if `addr[63:3]` ≥ DEPTH_WORDS.
  - Either condition sets `resp_err`=1.
  - Word index is `addr[3+log2(DEPTH_WORDS)-1:3]`.
- **Access at the commit edge:**
  - Load, no error: `resp_rdata` ← mem[index].
  - Store, no error: mem[index] ← wdata, and `resp_rdata` ← 0.
  - Any error: no array write, `resp_rdata` ← 0.
- Memory array contents are not reset. Only the control and response registers are reset.

## Timing
- Reset values, applied asynchronously on `resetl`=0:
  - state = IDLE.
  - `req_ready`=1 once reset is released. `req_ready` is 0 while `resetl`=0.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, counter=0.
- Latency: accept at edge N gives `resp_valid`=1 after edge N+LATENCY. With LATENCY=1, BUSY lasts exactly one cycle.
- Minimum request-to-request spacing is LATENCY+2 cycles when `resp_ready` is held at 1.
- **Backpressure:** `resp_ready`=0 holds RESP indefinitely. Outputs stay stable and `req_ready` stays 0.
- **Request ignored while busy:** `req_valid` asserted outside IDLE is not accepted. The requester must hold the request until `req_ready`.
- `req_*` inputs are sampled only at the accept edge. Later changes to them have no effect.
- **Reset mid-operation:**
  - An asserted reset aborts the transaction.
  - A store reset before its commit edge leaves memory unchanged.
  - A store reset after its commit edge stays written.
- **Read-after-write:** a store's data is visible to the next accepted load.

## Test plan
- **Reset:** assert `resetl`=0 mid-cycle, async.
  - Required: `req_ready`=0, `resp_valid`=0, `resp_rdata`=0 immediately.
  - Required after release: `req_ready`=1.
- **Store then load** (LATENCY=2): store addr 0x28, data 0xDEAD_BEEF_0123_4567, then load 0x28.
  - Required: store response 2 cycles after accept with `resp_err`=0 and `rdata`=0.
  - Required: load response has `rdata`=0xDEAD_BEEF_0123_4567 and `resp_err`=0.
- **Misaligned and out of range:**
  - Store to 0x2C: `resp_err`=1, and a subsequent load of 0x28 still returns the old value.
  - Load of 0x200 with DEPTH_WORDS=64: `resp_err`=1, `rdata`=0.
- **Backpressure:** hold `resp_ready`=0 for 3 cycles after `resp_valid`, with `req_valid` held high.
  - Required: `resp_valid` and `rdata` stable, `req_ready`=0 throughout.
  - Required: the next request is accepted exactly 1 cycle after the response handshake.
- **Reset in BUSY:** pulse `resetl` low during BUSY of a store to 0x10 (LATENCY=3, reset at accept+1).
  - Required: `resp_valid` is never asserted.
  - Required: a load of 0x10 after reset returns the pre-store value.
- **LATENCY=1 back-to-back:** 4 sequential loads with `resp_ready`=1.
  - Required: each `resp_valid` follows its accept by 1 cycle.
  - Required: accepts occur 3 cycles apart.
